// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweeper for an N_IN-input, 1-output combinational block.
// Drives every input vector in ascending order, samples F after a settle time, and compares the result to a latched golden table.
module truth_table_sequencer #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail
);

    localparam int unsigned TW = 2**N_IN;
    localparam int unsigned MW = N_IN + 1;
    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_q;
    logic [MW-1:0]   mm_q;
    logic [MW-1:0]   mm_d;
    logic [N_IN-1:0] ff_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic sample_c;
    logic miss_c;

    // The hold ends on the edge where the settle counter has reached SETTLE.
    assign sample_c = (cnt_q == CW'(SETTLE));
    assign miss_c   = (f_in != exp_q[vec_q]);
    assign mm_d     = miss_c ? (mm_q + MW'(1)) : mm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mm_q    <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        table_q <= '0;
                        mm_q    <= '0;
                        ff_q    <= '0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!sample_c) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        table_q[vec_q] <= f_in;
                        mm_q           <= mm_d;
                        if (miss_c && (mm_q == '0)) begin
                            ff_q <= vec_q;
                        end
                        // Final vector: publish results so they are visible alongside done.
                        if (vec_q == LAST_VEC) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (mm_d == '0);
                        end else begin
                            vec_q <= vec_q + N_IN'(1);
                            cnt_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign table_out    = table_q;
    assign mismatch_cnt = mm_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer driving a modelled F = A&B | C&D.
// Covers default SETTLE=2 sweeps, expected-table mismatches, start/expected changes mid-sweep, reset mid-sweep and a SETTLE=0 build.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;

    logic        start0;
    logic [15:0] expected0;
    logic [3:0]  vec_out0;
    logic        f_in0;
    logic        busy0;
    logic        done0;
    logic        pass0;
    logic [15:0] table_out0;
    logic [4:0]  mismatch_cnt0;
    logic [3:0]  first_fail0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic f_model(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    assign f_in  = f_model(vec_out);
    assign f_in0 = f_model(vec_out0);

    truth_table_sequencer #(.N_IN(4), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .vec_out(vec_out), .f_in(f_in), .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
    );

    truth_table_sequencer #(.N_IN(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(expected0),
        .vec_out(vec_out0), .f_in(f_in0), .busy(busy0), .done(done0), .pass(pass0),
        .table_out(table_out0), .mismatch_cnt(mismatch_cnt0), .first_fail(first_fail0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full SETTLE=2 sweep; optionally keeps start high and zeroes expected at vector 6.
    task automatic run_sweep(input logic [15:0] exp_tbl, input bit hold, input logic exp_pass,
                             input logic [4:0] exp_mm, input logic [3:0] exp_ff);
        int dones;
        dones    = 0;
        expected = exp_tbl;
        start    = 1'b1;
        step();
        if (!hold) start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("vec_at_start", 32'(vec_out), 32'd0);
        for (int e = 1; e <= 48; e++) begin
            step();
            if (done) dones++;
            if (hold && e == 18) expected = 16'h0000;
            if (e < 48 && (e % 3) == 0) chk("vec_step", 32'(vec_out), 32'(e / 3));
        end
        chk("done_at_48", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("pass", 32'(pass), 32'(exp_pass));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
        chk("first_fail", 32'(first_fail), 32'(exp_ff));
        chk("table_out", 32'(table_out), 32'h0000_F888);
        chk("vec_last", 32'(vec_out), 32'd15);
        start = 1'b0;
        step();
        if (done) dones++;
        chk("done_cleared", 32'(done), 32'd0);
        step();
        if (done) dones++;
        chk("done_count", 32'(dones), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("pass_hold", 32'(pass), 32'(exp_pass));
        chk("vec_hold", 32'(vec_out), 32'd15);
    endtask

    initial begin
        int dones;
        rst       = 1'b1;
        start     = 1'b0;
        start0    = 1'b0;
        expected  = 16'h0000;
        expected0 = 16'h0000;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_vec", 32'(vec_out), 32'd0);
        chk("rst_table", 32'(table_out), 32'd0);
        chk("rst_mm", 32'(mismatch_cnt), 32'd0);
        chk("rst_ff", 32'(first_fail), 32'd0);
        rst = 1'b0;
        step();

        run_sweep(16'hF888, 1'b0, 1'b1, 5'd0, 4'd0);
        run_sweep(16'hF880, 1'b0, 1'b0, 5'd1, 4'd3);
        run_sweep(16'h0777, 1'b0, 1'b0, 5'd16, 4'd0);
        run_sweep(16'hF888, 1'b1, 1'b1, 5'd0, 4'd0);

        // Reset while vector 5 is being driven.
        expected = 16'hF888;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 16; e++) step();
        chk("mid_vec5", 32'(vec_out), 32'd5);
        chk("mid_table", 32'(table_out), 32'h0000_0008);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_vec", 32'(vec_out), 32'd0);
        chk("rstmid_table", 32'(table_out), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_mm", 32'(mismatch_cnt), 32'd0);
        dones = 0;
        for (int e = 0; e < 60; e++) begin
            step();
            if (done) dones++;
        end
        chk("rstmid_no_done", 32'(dones), 32'd0);
        run_sweep(16'hF888, 1'b0, 1'b1, 5'd0, 4'd0);

        // SETTLE=0 build: one vector per cycle.
        expected0 = 16'hF888;
        start0    = 1'b1;
        step();
        start0 = 1'b0;
        chk("s0_busy", 32'(busy0), 32'd1);
        chk("s0_vec_start", 32'(vec_out0), 32'd0);
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e < 16) chk("s0_vec_step", 32'(vec_out0), 32'(e));
            if (e < 16) chk("s0_no_done", 32'(done0), 32'd0);
        end
        chk("s0_done", 32'(done0), 32'd1);
        chk("s0_pass", 32'(pass0), 32'd1);
        chk("s0_table", 32'(table_out0), 32'h0000_F888);
        chk("s0_mm", 32'(mismatch_cnt0), 32'd0);
        chk("s0_vec_last", 32'(vec_out0), 32'd15);
        step();
        chk("s0_done_cleared", 32'(done0), 32'd0);
        chk("s0_busy_idle", 32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
